rr_arb_4to1: RTL and testbench

- Upstream source stage for the 4-to-1 16-bit data mux: arbitrates four requesting sources (a, b, c, d) round-robin.
- Drives the 2-bit `sel` that steers the mux.
- Registers the winning word into a single-entry output slot with a valid/ready handshake toward the consumer.
- Guarantees one word per cycle at full throughput, fair service, and no lost or duplicated words under back-pressure.

---
 rtl/rr_arb_4to1.sv | 80 ++++++++
 tb/tb_rr_arb_4to1.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4to1.sv
// Round-robin 4-to-1 source arbiter feeding a single-entry registered output slot
// with a valid/ready handshake toward the consumer.
module rr_arb_4to1 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state;
  logic [1:0]       last;
  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic             gnt_any;
  logic             free;
  logic [WIDTH-1:0] win_data;

  assign y_valid = (state == FULL);
  assign free    = (state == EMPTY) || y_ready;

  // Scan last+1 .. last+4 (mod 4); the 2-bit add supplies the 3->0 wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    gnt_any = 1'b0;
    cand    = last;
    if (!rst && free) begin
      for (int unsigned k = 1; k <= 4; k++) begin
        cand = last + 2'(k);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) gnt = 4'b0001 << gnt_idx;
    end
  end

  always_comb begin
    win_data = '0;
    case (gnt_idx)
      2'd0:    win_data = a;
      2'd1:    win_data = b;
      2'd2:    win_data = c;
      default: win_data = d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      sel   <= 2'b00;
      last  <= 2'b11;
      state <= EMPTY;
    end else if (gnt_any) begin
      y     <= win_data;
      sel   <= gnt_idx;
      last  <= gnt_idx;
      state <= FULL;
    end else if (state == FULL && y_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed bench for rr_arb_4to1: per-cycle comparison against a behavioural
// model plus hand-computed literal expectations for each scenario.
module tb_rr_arb_4to1;

  logic        clk;
  logic        rst;
  logic [15:0] a, b, c, d;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] y;
  logic        y_valid;
  logic        y_ready;

  int errors = 0;
  int checks = 0;

  rr_arb_4to1 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .req(req), .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  int          m_last  = 3;
  bit          m_valid = 1'b0;
  logic [15:0] m_y     = '0;
  int          m_sel   = 0;
  bit          chk_en  = 1'b0;

  function automatic int model_grant();
    int g;
    g = -1;
    if (!rst && (!m_valid || y_ready)) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && req[(m_last + k) % 4]) g = (m_last + k) % 4;
      end
    end
    return g;
  endfunction

  function automatic logic [15:0] src_word(int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_y = '0; m_sel = 0; m_valid = 1'b0; m_last = 3; chk_en = 1'b1;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_y = src_word(g); m_sel = g; m_valid = 1'b1; m_last = g;
      end else if (m_valid && y_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] eg;
    if (chk_en) begin
      g  = model_grant();
      eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("model_gnt", 32'(gnt), 32'(eg));
      chk("model_y", 32'(y), 32'(m_y));
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_valid", 32'(y_valid), 32'(m_valid));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rr_exp [5];

  initial begin
    rst = 1'b1; req = '0; y_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    // 1: reset then single request
    cyc(); cyc();
    rst = 1'b0; req = 4'b0100; c = 16'h00FF; y_ready = 1'b1;
    #1 chk("t1_gnt", 32'(gnt), 32'h4);
    cyc(); req = 4'b0000;
    #1 chk("t1_y", 32'(y), 32'h00FF);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_valid", 32'(y_valid), 32'h1);
    cyc();
    #1 chk("t1_drain", 32'(y_valid), 32'h0);

    // 2: round robin from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0;
    a = 16'hAAAA; b = 16'h5555; c = 16'h005A; d = 16'h5A00; req = 4'b1111;
    rr_exp[0] = 16'hAAAA; rr_exp[1] = 16'h5555; rr_exp[2] = 16'h005A;
    rr_exp[3] = 16'h5A00; rr_exp[4] = 16'hAAAA;
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1 chk("t2_y", 32'(y), 32'(rr_exp[k]));
      chk("t2_sel", 32'(sel), 32'(k % 4));
      chk("t2_valid", 32'(y_valid), 32'h1);
    end

    // 3: back-pressure with b in the slot
    cyc(); y_ready = 1'b0;
    #1 chk("t3_gnt_stall", 32'(gnt), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1 chk("t3_y_hold", 32'(y), 32'h5555);
      chk("t3_sel_hold", 32'(sel), 32'h1);
      chk("t3_valid_hold", 32'(y_valid), 32'h1);
      chk("t3_gnt_hold", 32'(gnt), 32'h0);
    end
    y_ready = 1'b1;
    #1 chk("t3_gnt_release", 32'(gnt), 32'h4);
    cyc();
    #1 chk("t3_y_c", 32'(y), 32'h005A);

    // 4: skip and wrap
    cyc(); req = 4'b1010;
    #1 chk("t4_sel_d", 32'(sel), 32'h3);
    chk("t4_gnt_b", 32'(gnt), 32'h2);
    cyc(); req = 4'b1001;
    #1 chk("t4_sel_b", 32'(sel), 32'h1);
    chk("t4_gnt_d", 32'(gnt), 32'h8);
    cyc();
    #1 chk("t4_sel_d2", 32'(sel), 32'h3);
    chk("t4_gnt_a", 32'(gnt), 32'h1);
    cyc();
    #1 chk("t4_sel_a", 32'(sel), 32'h0);
    chk("t4_y_a", 32'(y), 32'hAAAA);

    // 5: reset mid-operation with a full slot
    req = 4'b0001; a = 16'hFF00;
    cyc(); y_ready = 1'b0; req = 4'b1111;
    #1 chk("t5_y_pre", 32'(y), 32'hFF00);
    rst = 1'b1;
    #1 chk("t5_gnt_rst", 32'(gnt), 32'h0);
    cyc();
    #1 chk("t5_y_rst", 32'(y), 32'h0);
    chk("t5_valid_rst", 32'(y_valid), 32'h0);
    chk("t5_sel_rst", 32'(sel), 32'h0);
    chk("t5_gnt_in_rst", 32'(gnt), 32'h0);
    rst = 1'b0;
    #1 chk("t5_gnt_a", 32'(gnt), 32'h1);

    // 6: empty idle leaves the pointer alone
    req = 4'b0010; y_ready = 1'b1;
    cyc(); req = 4'b0000;
    cyc();
    for (int k = 0; k < 4; k++) begin
      y_ready = (k % 2 == 0);
      cyc();
      #1 chk("t6_valid_idle", 32'(y_valid), 32'h0);
      chk("t6_gnt_idle", 32'(gnt), 32'h0);
    end
    req = 4'b1111;
    #1 chk("t6_gnt_next", 32'(gnt), 32'h4);
    cyc();
    #1 chk("t6_sel_next", 32'(sel), 32'h2);

    // Mixed traffic checked only by the model.
    for (int k = 0; k < 60; k++) begin
      req = 4'($urandom_range(0, 15));
      y_ready = 1'($urandom_range(0, 1));
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
